// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types: word length, receive error flags, receiver states.
package uart_pkg;

    typedef enum logic [1:0] {
        WL5 = 2'd0,
        WL6 = 2'd1,
        WL7 = 2'd2,
        WL8 = 2'd3
    } word_len_e;

    typedef struct packed {
        logic break_int;
        logic frame_err;
        logic parity_err;
    } rx_err_s;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop single-bit synchronizer with configurable reset value.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] r_ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ff <= {2{RESET_VAL}};
        end else begin
            r_ff <= {r_ff[0], d};
        end
    end

    assign q = r_ff[1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver, 5..8 data bits, optional parity, break detect.
// Define UART_RX_SYNC_EN to route rx through a 2-flop synchronizer first.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        baud_tick,
    input  logic        rx,
    input  word_len_e   word_len,
    input  logic        parity_en,
    input  logic        parity_even,
    input  logic        parity_stick,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output rx_err_s     rx_err,
    output logic        rx_busy
);

    localparam int              CW      = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]   CNT_MID = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0]   CNT_END = CW'(OVERSAMPLE - 1);

    logic w_rx;

`ifdef UART_RX_SYNC_EN
    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (w_rx)
    );
`else
    assign w_rx = rx;
`endif

    rx_state_e      r_state;
    rx_state_e      w_next;
    logic [CW-1:0]  r_cnt;
    logic [2:0]     r_bit;
    logic [7:0]     r_shift;
    word_len_e      r_wlen;
    logic           r_pen;
    logic           r_peven;
    logic           r_pstick;
    logic           r_par_bit;
    logic           r_par_err;
    logic           r_valid;
    logic [7:0]     r_data;
    rx_err_s        r_err;

    logic           w_mid;
    logic           w_end;
    logic           w_last;
    logic           w_busy;
    logic           w_par_exp;
    logic           w_break;

    assign w_mid  = baud_tick && (r_cnt == CNT_MID);
    assign w_end  = baud_tick && (r_cnt == CNT_END);
    assign w_last = (r_bit == ({1'b0, r_wlen} + 3'd4));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (baud_tick && !w_rx) w_next = START;
            START:     if (w_mid) w_next = w_rx ? IDLE : DATA;
            DATA:      if (w_end && w_last) w_next = r_pen ? PARITY : STOP;
            PARITY:    if (w_end) w_next = STOP;
            STOP:      if (w_end) w_next = w_rx ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (baud_tick && w_rx) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Break: every sampled bit of the frame low, stop included.
    always_comb begin
        w_busy    = (r_state != IDLE);
        w_par_exp = r_pstick ? ~r_peven : ((^r_shift) ^ ~r_peven);
        w_break   = (r_shift == 8'd0) && !(r_pen && r_par_bit) && !w_rx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_bit     <= 3'd0;
            r_shift   <= 8'd0;
            r_wlen    <= WL5;
            r_pen     <= 1'b0;
            r_peven   <= 1'b0;
            r_pstick  <= 1'b0;
            r_par_bit <= 1'b0;
            r_par_err <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= 8'd0;
            r_err     <= '0;
        end else begin
            r_valid <= 1'b0;
            if (baud_tick) begin
                case (r_state)
                    IDLE: begin
                        r_cnt     <= '0;
                        r_bit     <= 3'd0;
                        r_shift   <= 8'd0;
                        r_par_bit <= 1'b0;
                        r_par_err <= 1'b0;
                    end
                    START: begin
                        if (r_cnt == CNT_MID) begin
                            r_cnt    <= '0;
                            r_wlen   <= word_len;
                            r_pen    <= parity_en;
                            r_peven  <= parity_even;
                            r_pstick <= parity_stick;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    DATA, PARITY, STOP: begin
                        r_cnt <= (r_cnt == CNT_END) ? '0 : r_cnt + 1'b1;
                    end
                    default: r_cnt <= '0;
                endcase

                if (r_state == DATA && r_cnt == CNT_END) begin
                    r_shift[r_bit] <= w_rx;
                    r_bit          <= r_bit + 3'd1;
                end
                if (r_state == PARITY && r_cnt == CNT_END) begin
                    r_par_bit <= w_rx;
                    r_par_err <= (w_rx != w_par_exp);
                end
                if (r_state == STOP && r_cnt == CNT_END) begin
                    r_valid          <= 1'b1;
                    r_data           <= r_shift;
                    r_err.break_int  <= w_break;
                    r_err.frame_err  <= ~w_rx;
                    r_err.parity_err <= r_par_err;
                end
            end
        end
    end

    assign rx_valid = r_valid;
    assign rx_data  = r_data;
    assign rx_err   = r_err;
    assign rx_busy  = w_busy;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a frame-level reference model.
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx = 1'b1;
    word_len_e  word_len = WL8;
    logic       parity_en = 1'b0;
    logic       parity_even = 1'b0;
    logic       parity_stick = 1'b0;
    logic       rx_valid;
    logic [7:0] rx_data;
    rx_err_s    rx_err;
    logic       rx_busy;

    int n_checks = 0;
    int n_fail = 0;
    int tick_div = 1;
    int tick_ctr = 0;

    logic [7:0] q_data[$];
    logic [2:0] q_err[$];

    uart_rx #(.OVERSAMPLE(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_tick    (baud_tick),
        .rx           (rx),
        .word_len     (word_len),
        .parity_en    (parity_en),
        .parity_even  (parity_even),
        .parity_stick (parity_stick),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_err       (rx_err),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tick_ctr++;
        baud_tick = ((tick_ctr % tick_div) == 0);
    end

    always @(negedge clk) begin
        if (rx_valid) begin
            q_data.push_back(rx_data);
            q_err.push_back(rx_err);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    // Hold the line at b for n baud ticks as seen by the DUT.
    task automatic hold_bit(input logic b, input int n);
        int cnt = 0;
        @(negedge clk);
        rx = b;
        while (cnt < n) begin
            @(posedge clk);
            if (baud_tick) cnt++;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic has_par,
                              input logic pbit, input logic stop, input logic scramble);
        hold_bit(1'b0, 16);
        if (scramble) begin
            word_len     = word_len_e'($urandom_range(0, 3));
            parity_en    = 1'($urandom);
            parity_even  = 1'($urandom);
            parity_stick = 1'($urandom);
        end
        for (int i = 0; i < nbits; i++) hold_bit(d[i], 16);
        if (has_par) hold_bit(pbit, 16);
        hold_bit(stop, 16);
    endtask

    // Expected {break, frame, parity, data} for one frame.
    function automatic logic [10:0] model(input logic [7:0] d, input int nbits, input logic pen,
                                          input logic pev, input logic pst, input logic pbit,
                                          input logic stop);
        logic [7:0] dm;
        logic       exp_p;
        logic       perr;
        logic       brk;
        dm    = d & 8'((1 << nbits) - 1);
        exp_p = pst ? !pev : ((($countones(dm) % 2) == 1) ^ !pev);
        perr  = pen && (pbit != exp_p);
        brk   = (dm == 8'd0) && !(pen && pbit) && !stop;
        return {brk, !stop, perr, dm};
    endfunction

    task automatic set_cfg(input int nbits, input logic pen, input logic pev, input logic pst);
        word_len     = word_len_e'(2'(nbits - 5));
        parity_en    = pen;
        parity_even  = pev;
        parity_stick = pst;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rx_valid, rx_data, rx_err, rx_busy} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs actual=%h required=0", {rx_valid, rx_data, rx_err, rx_busy});
        end
        rst = 1'b0;
        hold_bit(1'b1, 4);
    endtask

    task automatic test_8n1();
        tick_div = 1;
        set_cfg(8, 0, 0, 0);
        q_data.delete(); q_err.delete();
        send_frame(8'hA5, 8, 0, 0, 1, 0);
        hold_bit(1'b1, 4);
        n_checks++;
        if (q_data.size() != 1) begin
            n_fail++;
            $display("FAIL 8n1_count actual=%0d required=1", q_data.size());
        end else begin
            n_checks++;
            if (q_data[0] !== 8'hA5 || q_err[0] !== 3'b000) begin
                n_fail++;
                $display("FAIL 8n1_frame actual=%h/%b required=a5/000", q_data[0], q_err[0]);
            end
        end
        n_checks++;
        if (rx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL 8n1_busy actual=%b required=0", rx_busy);
        end
    endtask

    task automatic test_parity_7e1();
        logic [7:0] exp_d[2] = '{8'h35, 8'h35};
        logic [2:0] exp_e[2] = '{3'b001, 3'b000};
        set_cfg(7, 1, 1, 0);
        q_data.delete(); q_err.delete();
        send_frame(8'h35, 7, 1, 1, 1, 0);
        send_frame(8'h35, 7, 1, 0, 1, 0);
        hold_bit(1'b1, 30);
        n_checks++;
        if (q_data.size() != 2) begin
            n_fail++;
            $display("FAIL 7e1_count actual=%0d required=2", q_data.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (q_data[i] !== exp_d[i] || q_err[i] !== exp_e[i]) begin
                    n_fail++;
                    $display("FAIL 7e1_frame%0d actual=%h/%b required=%h/%b",
                             i, q_data[i], q_err[i], exp_d[i], exp_e[i]);
                end
            end
        end
        n_checks++;
        if (rx_data !== 8'h35 || rx_err !== 3'b000) begin
            n_fail++;
            $display("FAIL hold_last actual=%h/%b required=35/000", rx_data, rx_err);
        end
    endtask

    task automatic test_glitch();
        set_cfg(8, 0, 0, 0);
        q_data.delete(); q_err.delete();
        hold_bit(1'b0, 5);
        #1;
        n_checks++;
        if (rx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_busy_during actual=%b required=1", rx_busy);
        end
        hold_bit(1'b1, 20);
        #1;
        n_checks++;
        if (q_data.size() != 0 || rx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_reject actual=%0d/%b required=0/0", q_data.size(), rx_busy);
        end
    endtask

    task automatic test_break();
        set_cfg(8, 0, 0, 0);
        q_data.delete(); q_err.delete();
        hold_bit(1'b0, 40 * 16);
        hold_bit(1'b1, 4);
        #1;
        n_checks++;
        if (q_data.size() != 1) begin
            n_fail++;
            $display("FAIL break_count actual=%0d required=1", q_data.size());
        end else begin
            n_checks++;
            if (q_data[0] !== 8'h00 || q_err[0] !== 3'b110) begin
                n_fail++;
                $display("FAIL break_frame actual=%h/%b required=00/110", q_data[0], q_err[0]);
            end
        end
        n_checks++;
        if (rx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL break_idle actual=%b required=0", rx_busy);
        end
    endtask

    task automatic test_stick5();
        set_cfg(5, 1, 1, 1);
        q_data.delete(); q_err.delete();
        send_frame(8'h1F, 5, 1, 0, 1, 0);
        send_frame(8'h1F, 5, 1, 1, 1, 0);
        hold_bit(1'b1, 4);
        n_checks++;
        if (q_data.size() != 2) begin
            n_fail++;
            $display("FAIL stick5_count actual=%0d required=2", q_data.size());
        end else begin
            n_checks++;
            if (q_data[0] !== 8'h1F || q_err[0] !== 3'b000) begin
                n_fail++;
                $display("FAIL stick5_ok actual=%h/%b required=1f/000", q_data[0], q_err[0]);
            end
            n_checks++;
            if (q_data[1] !== 8'h1F || q_err[1] !== 3'b001) begin
                n_fail++;
                $display("FAIL stick5_bad actual=%h/%b required=1f/001", q_data[1], q_err[1]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d = 8'h55;
        set_cfg(8, 0, 0, 0);
        q_data.delete(); q_err.delete();
        hold_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) hold_bit(d[i], 16);
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        #1;
        n_checks++;
        if (rx_busy !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_outputs actual=%b/%b/%h required=0/0/00", rx_busy, rx_valid, rx_data);
        end
        @(negedge clk);
        rst = 1'b0;
        hold_bit(1'b1, 20);
        n_checks++;
        if (q_data.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_nopush actual=%0d required=0", q_data.size());
        end
        send_frame(8'h3C, 8, 0, 0, 1, 0);
        hold_bit(1'b1, 4);
        n_checks++;
        if (q_data.size() != 1 || q_data[0] !== 8'h3C || q_err[0] !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset_next actual=%0d/%h required=1/3c",
                     q_data.size(), (q_data.size() > 0) ? q_data[0] : 8'hxx);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 24; f++) begin
            int         nbits;
            logic       pen, pev, pst, pbit, stop;
            logic [7:0] d;
            logic [10:0] exp;
            tick_div = $urandom_range(1, 3);
            nbits = $urandom_range(5, 8);
            pen   = 1'($urandom);
            pev   = 1'($urandom);
            pst   = 1'($urandom);
            pbit  = 1'($urandom);
            stop  = ($urandom_range(0, 7) != 0);
            d     = (f % 6 == 5) ? 8'h00 : 8'($urandom);
            exp   = model(d, nbits, pen, pev, pst, pbit, stop);
            set_cfg(nbits, pen, pev, pst);
            q_data.delete(); q_err.delete();
            send_frame(d, nbits, pen, pbit, stop, 1);
            hold_bit(1'b1, 2);
            n_checks++;
            if (q_data.size() != 1 || q_data[0] !== exp[7:0] || q_err[0] !== exp[10:8]) begin
                n_fail++;
                $display("FAIL random_frame%0d actual=%0d/%h/%b required=1/%h/%b", f, q_data.size(),
                         (q_data.size() > 0) ? q_data[0] : 8'hxx,
                         (q_err.size() > 0) ? q_err[0] : 3'bxxx, exp[7:0], exp[10:8]);
            end
        end
        tick_div = 1;
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity_7e1();
        test_glitch();
        test_break();
        test_stick5();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
